// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with valid/ready handshake and a 2-entry skid buffer.
// CTRL is squashed on bubbles/flush; DATA optionally cleared; saturating stall/flush counters.
module pipe_stage_skid #(
  parameter int unsigned CTRL_W     = 8,
  parameter int unsigned DATA_W     = 96,
  parameter int unsigned CLEAR_DATA = 0,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state;
  logic [CTRL_W-1:0] main_ctrl;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] main_data;
  logic [DATA_W-1:0] skid_data;
  logic              in_fire;
  logic              out_fire;

  // Handshake flags decode straight from the state register, so in_ready has no input path.
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign out_ctrl  = out_valid ? main_ctrl : '0;
  assign out_data  = main_data;

  always_comb begin
    occupancy = 2'd0;
    case (state)
      ONE:     occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= EMPTY;
      main_ctrl <= '0;
      skid_ctrl <= '0;
      main_data <= '0;
      skid_data <= '0;
    end else if (flush) begin
      state     <= EMPTY;
      main_ctrl <= '0;
      skid_ctrl <= '0;
      if (CLEAR_DATA != 0) begin
        main_data <= '0;
        skid_data <= '0;
      end
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            main_ctrl <= in_ctrl;
            main_data <= in_data;
            state     <= ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_ctrl <= in_ctrl;
            main_data <= in_data;
          end else if (in_fire) begin
            skid_ctrl <= in_ctrl;
            skid_data <= in_data;
            state     <= FULL;
          end else if (out_fire) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_ctrl <= skid_ctrl;
            main_data <= skid_data;
            state     <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && !flush && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (flush && (state != EMPTY) && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule
